// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with shadow registers and anti-ghost blanking
// Registered, active-low outputs; one digit slot per REFRESH_DIV cycles, first cycle of each slot dark.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      w_enable,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank,
  output logic [NUM_DIGITS-1:0]     digit_select,
  output logic [6:0]                write_this,
  output logic                      dp_out
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   shadow_value;
  logic [NUM_DIGITS-1:0]     shadow_en;
  logic [NUM_DIGITS-1:0]     shadow_dp;

  logic [NUM_DIGITS-1:0]     lz_mask;
  logic                      zeros_above;
  logic [3:0]                cur_nibble;
  logic                      drive;
  logic [NUM_DIGITS-1:0]     sel_one_cold;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // A digit is suppressed when it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    zeros_above = 1'b1;
    lz_mask     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros_above = zeros_above && (shadow_value[4*i +: 4] == 4'h0);
      lz_mask[i]  = LZ_BLANK && (i != 0) && zeros_above;
    end
  end

  always_comb begin
    cur_nibble   = shadow_value[{idx, 2'b00} +: 4];
    drive        = (cnt != '0) && !blank && shadow_en[idx] && !lz_mask[idx];
    sel_one_cold = ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_en    <= '0;
      shadow_dp    <= '0;
      digit_select <= '1;
      write_this   <= 7'h7F;
      dp_out       <= 1'b1;
    end else begin
      if (w_enable) begin
        shadow_value <= value;
        shadow_en    <= digit_en;
        shadow_dp    <= dp_in;
      end

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (drive) begin
        digit_select <= sel_one_cold;
        write_this   <= hex_glyph(cur_nibble);
        dp_out       <= ~shadow_dp[idx];
      end else begin
        digit_select <= '1;
        write_this   <= 7'h7F;
        dp_out       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
// Two instances (LZ_BLANK 0 and 1) share inputs; NUM_DIGITS=4, REFRESH_DIV=4.
module tb_seg7_scan_driver;

  logic        clock;
  logic        resetn;
  logic        w_enable;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic        blank;
  logic [3:0]  digit_select,    lz_digit_select;
  logic [6:0]  write_this,      lz_write_this;
  logic        dp_out,          lz_dp_out;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut (
    .clock(clock), .resetn(resetn), .w_enable(w_enable), .value(value),
    .digit_en(digit_en), .dp_in(dp_in), .blank(blank),
    .digit_select(digit_select), .write_this(write_this), .dp_out(dp_out)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut_lz (
    .clock(clock), .resetn(resetn), .w_enable(w_enable), .value(value),
    .digit_en(digit_en), .dp_in(dp_in), .blank(blank),
    .digit_select(lz_digit_select), .write_this(lz_write_this), .dp_out(lz_dp_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] ds, input logic [6:0] ws, input logic dp);
    check({tag, ".sel"}, 32'(digit_select), 32'(ds));
    check({tag, ".seg"}, 32'(write_this),   32'(ws));
    check({tag, ".dp"},  32'(dp_out),       32'(dp));
  endtask

  task automatic check_lz(input string tag, input logic [3:0] ds, input logic [6:0] ws);
    check({tag, ".lzsel"}, 32'(lz_digit_select), 32'(ds));
    check({tag, ".lzseg"}, 32'(lz_write_this),   32'(ws));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;
    int c, ix;
    resetn = 1'b0; w_enable = 1'b0; value = '0; digit_en = '0; dp_in = '0; blank = 1'b0;
    tick(2);
    check_out("reset", 4'hF, 7'h7F, 1'b1);

    // Release with a load of 1234; edge k samples cnt=(k-1)%4, idx=((k-1)/4)%4.
    resetn = 1'b1; w_enable = 1'b1; value = 16'h1234; digit_en = 4'hF; dp_in = 4'h0;
    tick(1); w_enable = 1'b0;
    check_out("s0_dark", 4'hF, 7'h7F, 1'b1);
    tick(1); check_out("s0_4", 4'b1110, 7'b0011001, 1'b1);
    tick(3); check_out("s1_dark", 4'hF, 7'h7F, 1'b1);
    tick(1); check_out("s1_3", 4'b1101, 7'b0110000, 1'b1);

    // Load 80F0 mid-slot 1 (edge 7), new nibble visible from edge 8.
    w_enable = 1'b1; value = 16'h80F0; dp_in = 4'b0100;
    tick(1); w_enable = 1'b0;
    check_out("s1_old3", 4'b1101, 7'b0110000, 1'b1);
    tick(1); check_out("s1_F", 4'b1101, 7'b0001110, 1'b1);
    tick(2); check_out("s2_0dp", 4'b1011, 7'b1000000, 1'b0);
    tick(4); check_out("s3_8", 4'b0111, 7'b0000000, 1'b1);
    check_lz("s3_8", 4'b0111, 7'b0000000);

    // Leading-zero suppression with 0070 (loaded at edge 15).
    w_enable = 1'b1; value = 16'h0070; dp_in = 4'h0;
    tick(1); w_enable = 1'b0;
    tick(1);
    check_out("lz_d3_plain", 4'b0111, 7'b1000000, 1'b1);
    check_lz("lz_d3", 4'hF, 7'h7F);
    tick(2); check_lz("lz_d0", 4'b1110, 7'b1000000);
    tick(4); check_lz("lz_d1", 4'b1101, 7'b1111000);
    tick(4); check_lz("lz_d2", 4'hF, 7'h7F);
    check_out("lz_d2_plain", 4'b1011, 7'b1000000, 1'b1);

    // Blank for edges 27..36; scan position must be unaffected.
    blank = 1'b1;
    for (int k = 27; k <= 36; k++) begin
      tick(1);
      check("blank.sel", 32'(digit_select), 32'hF);
      check("blank.seg", 32'(write_this), 32'h7F);
    end
    blank = 1'b0;
    tick(1); check_out("unblank_dark", 4'hF, 7'h7F, 1'b1);
    tick(1); check_out("unblank_d1", 4'b1101, 7'b1111000, 1'b1);

    // Reset in the middle of slot 2 (edge 42 shows digit 2).
    tick(4); check_out("pre_rst_d2", 4'b1011, 7'b1000000, 1'b1);
    #2 resetn = 1'b0;
    #1 check_out("async_rst", 4'hF, 7'h7F, 1'b1);
    @(negedge clock);
    resetn = 1'b1; w_enable = 1'b0;
    tick(1); check_out("post_rst_e1", 4'hF, 7'h7F, 1'b1);
    tick(1); check_out("post_rst_noen", 4'hF, 7'h7F, 1'b1);
    w_enable = 1'b1; value = 16'h1234; digit_en = 4'hF;
    tick(1); w_enable = 1'b0;
    tick(1); check_out("reload_4", 4'b1110, 7'b0011001, 1'b1);

    // digit_en = 0101 loaded at edge 5'; model the select for edges 6'..21'.
    w_enable = 1'b1; digit_en = 4'b0101;
    tick(1); w_enable = 1'b0;
    for (int k = 6; k <= 21; k++) begin
      tick(1);
      c  = (k - 1) % 4;
      ix = ((k - 1) / 4) % 4;
      e  = 4'hF;
      if (c != 0 && digit_en[ix]) e[ix] = 1'b0;
      check("en_mask.sel", 32'(digit_select), 32'(e));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (>=2).
REQ-003 SHALL have parameter LZ_BLANK, default 0, leading-zero suppression enable.
REQ-004 SHALL have port clock  input  1  single rising-edge clock.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port w_enable  input  1  load strobe for value/digit_en/dp_in.
REQ-007 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i.
REQ-008 SHALL have port digit_en  input  NUM_DIGITS  per-digit enable mask.
REQ-009 SHALL have port dp_in  input  NUM_DIGITS  per-digit decimal point request.
REQ-010 SHALL have port blank  input  1  force display dark while high.
REQ-011 SHALL have port digit_select  output  NUM_DIGITS  one-cold anode select, active-low.
REQ-012 SHALL have port write_this  output  7  segments {g,f,e,d,c,b,a}, bit0=a, active-low.
REQ-013 SHALL have port dp_out  output  1  decimal point, active-low.

Function
REQ-014 SHALL capture value, digit_en, dp_in into shadow registers on every rising edge with w_enable=1; shadows hold otherwise.
REQ-015 SHALL run slot counter cnt 0..REFRESH_DIV-1, wrapping to 0.
REQ-016 SHALL advance digit index idx when cnt==REFRESH_DIV-1, wrapping NUM_DIGITS-1 -> 0.
REQ-017 SHALL register all outputs; outputs at edge t+1 reflect cnt, idx, shadows, blank sampled at edge t.
REQ-018 SHALL drive a blank cycle (digit_select all 1, write_this 7'h7F, dp_out 1) whenever cnt==0 (anti-ghosting).
REQ-019 SHALL otherwise drive digit_select with only bit idx low, when shadow digit_en[idx]=1 and not suppressed.
REQ-020 SHALL decode nibble idx to standard hex glyphs 0-9, A, b, C, d, E, F, active-low.
REQ-021 SHALL drive dp_out = ~shadow dp[idx] while the digit is driven.
REQ-022 SHALL, for disabled or suppressed digits, output digit_select all 1, write_this 7'h7F, dp_out 1; scan timing unchanged.
REQ-023 SHALL, when LZ_BLANK=1, suppress digit i>0 if nibbles i..NUM_DIGITS-1 are all zero; digit 0 never suppressed.
REQ-024 SHALL, with blank=1, force the dark output pattern; cnt and idx keep running.
REQ-025 SHALL, when w_enable and slot advance coincide, show the new shadow value in the next slot.
REQ-026 SHALL never drive more than one digit_select bit low in any cycle.

Reset
REQ-027 SHALL, on resetn low, immediately set digit_select all 1, write_this 7'h7F, dp_out 1.
REQ-028 SHALL, on resetn low, clear cnt, idx, shadow value, shadow digit_en, shadow dp to 0.
REQ-029 SHALL resume scanning from idx=0, cnt=0 on first edge after resetn deasserts; reset mid-slot aborts the slot.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-030 SHALL check: load value=16'h1234, digit_en=4'hF -> slot 0 shows digit_select 1110/write_this 0011001 ("4"), slot 1 shows 1101/0110000 ("3"), first cycle of each slot dark.
REQ-031 SHALL check: value=16'h80F0, dp_in=4'b0100 -> digit 1 write_this 0001110 ("F"), digit 2 dp_out 0, digit 3 write_this 0000000 ("8").
REQ-032 SHALL check: LZ_BLANK=1, value=16'h0070 -> digits 3,2 dark, digit 1 "7" (1111000), digit 0 "0" (1000000).
REQ-033 SHALL check: blank=1 for 10 cycles -> outputs dark; idx after release equals uninterrupted count.
REQ-034 SHALL check: resetn low mid-slot 2 -> outputs dark asynchronously; after release slot 0 shows digit_en=0 dark until reload.
REQ-035 SHALL check: digit_en=4'b0101 over 16 cycles -> digit_select only ever 1110, 1011 or 1111.
